mac_sequencer: RTL and testbench
================================

# mac_sequencer

Control FSM that sequences one MAC instance through a single neuron dot product. On START it captures the job, loads the bias, and streams LEN weight/activation index pairs from two synchronous-read RAMs (1-cycle latency) into the MAC. It then requantises the 16-bit accumulator to an 8-bit activation and holds it under a valid/ready handshake. One sequencer sits beside each MAC in the NPU layer engine.

## Interface
- ADDR_W, default 10, width of the RAM addresses and of LEN.
- CLKEXT  in  1  system clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- START  in  1  job request; sampled only in IDLE.
- LEN  in  ADDR_W  number of products to accumulate; 0 is legal.
- W_BASE  in  ADDR_W  first weight address.
- X_BASE  in  ADDR_W  first activation address.
- BIAS  in  8  neuron bias.
- SHIFT  in  4  requantisation right-shift.
- BUSY  out  1  high in every state except IDLE.
- W_ADDR, X_ADDR  out  ADDR_W  RAM read addresses.
- MEM_RD  out  1  read strobe; RAM data for the address is valid the next cycle.
- RST_MAC  out  1  drives the MAC's bias-load/reset input.
- EN_MAC  out  1  drives the MAC's operand enable.
- BIAS_OUT  out  8  drives the MAC's BIAS_IN.
- MAC_RESULT  in  16  MAC accumulator.
- OUT_VALID  out  1  NEURON_OUT is valid.
- OUT_READY  in  1  consumer accepts the result.
- NEURON_OUT  out  8  requantised result.

## Operation
- Job capture: START in IDLE registers LEN, W_BASE, X_BASE, BIAS and SHIFT. Later changes to these inputs have no effect on the running job. START in any other state is ignored.
- The FSM has five states: IDLE, LOAD, STREAM, SETTLE, OUT.
- IDLE
  - All strobes are low.
  - START moves the FSM to LOAD.
- LOAD (1 cycle)
  - RST_MAC=1, so the MAC register takes {8'b0,BIAS_OUT}.
  - If LEN≠0, MEM_RD=1 with addresses W_BASE+0 and X_BASE+0.
  - Next state is STREAM if LEN≠0, otherwise SETTLE.
- STREAM (LEN cycles, index k = 1..LEN)
  - EN_MAC=1, consuming the data for address k-1.
  - MEM_RD=1 with addresses base+k while k<LEN.
  - After cycle k=LEN, the next state is SETTLE.
- SETTLE (1 cycle)
  - All strobes are low. MAC_RESULT is now final.
  - Register NEURON_OUT = min(MAC_RESULT >> SHIFT, 255).
  - Next state is OUT.
- OUT
  - OUT_VALID=1 and NEURON_OUT is held stable.
  - OUT_VALID && OUT_READY returns the FSM to IDLE.
  - START is not accepted in the same cycle as the handshake.
- Address arithmetic is modulo 2^ADDR_W; base+k wraps silently.
- The accumulator wraps modulo 2^16 inside the MAC. The sequencer neither detects nor flags overflow.
- Saturation: any shifted value ≥256 becomes 255.
- RST_MAC and EN_MAC are never high in the same cycle.
- BIAS_OUT always drives the captured bias, and is 0 after reset.

## Timing
- START is sampled at edge 0. LOAD occupies cycle 1, STREAM cycles 2..LEN+1, SETTLE cycle LEN+2.
- OUT_VALID first rises in cycle LEN+3. START-to-valid latency is therefore LEN+3 cycles (3 when LEN=0).
- MEM_RD is high in cycles 1..LEN, for exactly LEN reads.
- EN_MAC is high in cycles 2..LEN+1, for exactly LEN enables.
- Back-to-back throughput is LEN+4 cycles per job with OUT_READY tied high: the handshake cycle is followed by one IDLE cycle.
- Reset values (RSTN=0 at an edge): state=IDLE. BUSY, MEM_RD, RST_MAC, EN_MAC, OUT_VALID, W_ADDR, X_ADDR, NEURON_OUT and BIAS_OUT are all 0.
- Reset mid-job: the sequence aborts in the same edge and no OUT_VALID is produced. The MAC is not cleared by the sequencer; the next LOAD overwrites it.
- OUT_READY is ignored outside OUT.
- OUT_VALID must not drop before the handshake.

## Test plan
- Bias only: LEN=0, BIAS=37, SHIFT=0, OUT_READY=1.
  - Expect one RST_MAC pulse and no MEM_RD or EN_MAC.
  - OUT_VALID at cycle 3 with NEURON_OUT=37.
- Short dot product: LEN=3, W={2,3,4}, X={5,6,7}, BIAS=1, SHIFT=0.
  - MAC_RESULT=57, NEURON_OUT=57.
  - OUT_VALID at cycle 6; MEM_RD and EN_MAC each high for exactly 3 cycles, offset by one cycle.
- Shift and saturation:
  - LEN=2, W=X={255,255}, BIAS=0, SHIFT=4: result 130050 wraps to 64514, giving 4032 and NEURON_OUT=255.
  - Same job with SHIFT=8 gives NEURON_OUT=252.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID.
  - OUT_VALID and NEURON_OUT stay stable.
  - A START pulse during the wait is ignored (BUSY=1, no new LOAD).
  - After OUT_READY=1: IDLE next cycle.
- Address wrap: ADDR_W=10, W_BASE=1022, LEN=4 → W_ADDR sequence 1022, 1023, 0, 1.
- Reset mid-stream: RSTN=0 during STREAM of a LEN=784 job.
  - All outputs are 0 next cycle and no OUT_VALID appears.
  - A following LEN=1 job gives the correct result.

Source files
------------

// File: rtl/mac_sequencer.sv
// Sequences one MAC through a single neuron dot product: bias load, LEN
// operand pairs streamed from two 1-cycle-latency RAMs, then requantisation.
module mac_sequencer #(
   parameter int ADDR_W = 10
) (
   input  logic              CLKEXT,
   input  logic              RSTN,
   input  logic              START,
   input  logic [ADDR_W-1:0] LEN,
   input  logic [ADDR_W-1:0] W_BASE,
   input  logic [ADDR_W-1:0] X_BASE,
   input  logic [7:0]        BIAS,
   input  logic [3:0]        SHIFT,
   output logic              BUSY,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [ADDR_W-1:0] X_ADDR,
   output logic              MEM_RD,
   output logic              RST_MAC,
   output logic              EN_MAC,
   output logic [7:0]        BIAS_OUT,
   input  logic [15:0]       MAC_RESULT,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [7:0]        NEURON_OUT
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      STREAM = 3'd2,
      SETTLE = 3'd3,
      OUT    = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;
   logic [ADDR_W-1:0] len_reg, w_base_reg, x_base_reg;
   logic [7:0]        bias_reg;
   logic [3:0]        shift_reg;
   logic [7:0]        neuron_reg;

   logic              capture;
   logic              mem_rd;
   logic [ADDR_W-1:0] rd_off;
   logic              rst_mac;
   logic              en_mac;
   logic              out_valid;
   logic [15:0]       shifted;
   logic [7:0]        sat_value;

   assign shifted   = MAC_RESULT >> shift_reg;
   assign sat_value = (shifted[15:8] != 8'd0) ? 8'hFF : shifted[7:0];

   always_ff @(posedge CLKEXT) begin
      if (!RSTN) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         len_reg    <= '0;
         w_base_reg <= '0;
         x_base_reg <= '0;
         bias_reg   <= '0;
         shift_reg  <= '0;
         neuron_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (capture) begin
            len_reg    <= LEN;
            w_base_reg <= W_BASE;
            x_base_reg <= X_BASE;
            bias_reg   <= BIAS;
            shift_reg  <= SHIFT;
         end
         if (state_reg == SETTLE) begin
            neuron_reg <= sat_value;
         end
      end
   end

   // cnt_reg holds k (1..LEN) during STREAM; it doubles as the next read offset.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      mem_rd     = 1'b0;
      rd_off     = '0;
      rst_mac    = 1'b0;
      en_mac     = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (START) begin
               capture    = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD: begin
            rst_mac  = 1'b1;
            cnt_next = ADDR_W'(1);
            if (len_reg != '0) begin
               mem_rd     = 1'b1;
               state_next = STREAM;
            end else begin
               state_next = SETTLE;
            end
         end
         STREAM: begin
            en_mac = 1'b1;
            if (cnt_reg != len_reg) begin
               mem_rd   = 1'b1;
               rd_off   = cnt_reg;
               cnt_next = cnt_reg + ADDR_W'(1);
            end else begin
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            state_next = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (OUT_READY) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign BUSY       = (state_reg != IDLE);
   assign MEM_RD     = mem_rd;
   assign W_ADDR     = mem_rd ? (w_base_reg + rd_off) : '0;
   assign X_ADDR     = mem_rd ? (x_base_reg + rd_off) : '0;
   assign RST_MAC    = rst_mac;
   assign EN_MAC     = en_mac;
   assign BIAS_OUT   = bias_reg;
   assign OUT_VALID  = out_valid;
   assign NEURON_OUT = neuron_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural weight/activation RAMs and MAC around
// the DUT, table of directed jobs plus hand-written multi-cycle sequences.
module tb_mac_sequencer;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rstn;
   logic              start;
   logic [ADDR_W-1:0] len, w_base, x_base;
   logic [7:0]        bias;
   logic [3:0]        shift;
   logic              busy;
   logic [ADDR_W-1:0] w_addr, x_addr;
   logic              mem_rd, rst_mac, en_mac;
   logic [7:0]        bias_out;
   logic [15:0]       mac_result;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        neuron_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mac_sequencer #(.ADDR_W(ADDR_W)) dut (
      .CLKEXT(clk), .RSTN(rstn), .START(start), .LEN(len),
      .W_BASE(w_base), .X_BASE(x_base), .BIAS(bias), .SHIFT(shift),
      .BUSY(busy), .W_ADDR(w_addr), .X_ADDR(x_addr), .MEM_RD(mem_rd),
      .RST_MAC(rst_mac), .EN_MAC(en_mac), .BIAS_OUT(bias_out),
      .MAC_RESULT(mac_result), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .NEURON_OUT(neuron_out)
   );

   // Environment: synchronous-read RAMs and an 8x8 unsigned MAC wrapping at 16 bits.
   logic [7:0]  w_mem [1024];
   logic [7:0]  x_mem [1024];
   logic [7:0]  w_q, x_q;
   logic [15:0] acc;

   always @(posedge clk) begin
      if (mem_rd) begin
         w_q <= w_mem[w_addr];
         x_q <= x_mem[x_addr];
      end
      if (rst_mac)
         acc <= {8'd0, bias_out};
      else if (en_mac)
         acc <= acc + 16'(w_q) * 16'(x_q);
   end
   assign mac_result = acc;

   typedef struct {
      int len;
      int w_base;
      int x_base;
      int bias;
      int shift;
      int exp_out;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Runs one job. With bp set, the consumer stalls 5 cycles and a START
   // pulse is issued during the stall, which must be ignored.
   task automatic run_job(input vec_t v, input bit bp);
      int lat, rd_n, en_n, rst_n, ovl, first_rd, first_en, k;
      lat = -1; rd_n = 0; en_n = 0; rst_n = 0; ovl = 0; first_rd = -1; first_en = -1;
      @(negedge clk);
      out_ready = !bp;
      len = ADDR_W'(v.len); w_base = ADDR_W'(v.w_base); x_base = ADDR_W'(v.x_base);
      bias = 8'(v.bias); shift = 4'(v.shift);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble job inputs: the captured copy must be used.
      len = ADDR_W'($urandom); w_base = ADDR_W'($urandom); x_base = ADDR_W'($urandom);
      bias = 8'($urandom); shift = 4'($urandom);
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         if (mem_rd) begin
            if (first_rd < 0) first_rd = c;
            check("w_addr", int'(w_addr), (v.w_base + rd_n) % 1024);
            check("x_addr", int'(x_addr), (v.x_base + rd_n) % 1024);
            rd_n++;
         end
         if (en_mac) begin
            if (first_en < 0) first_en = c;
            en_n++;
         end
         if (rst_mac) rst_n++;
         if (rst_mac && en_mac) ovl++;
         if (out_valid) begin
            lat = c;
            break;
         end
      end
      check("latency", lat, v.len + 3);
      check("mem_rd_count", rd_n, v.len);
      check("en_mac_count", en_n, v.len);
      check("rst_mac_count", rst_n, 1);
      check("rst_en_overlap", ovl, 0);
      if (v.len > 0) begin
         check("first_rd_cycle", first_rd, 1);
         check("first_en_cycle", first_en, 2);
      end
      if (lat > 0) begin
         check("neuron_out", int'(neuron_out), v.exp_out);
         check("bias_out", int'(bias_out), v.bias);
         if (bp) begin
            for (k = 0; k < 5; k++) begin
               start = (k == 2);
               @(negedge clk);
               check("bp_valid", int'(out_valid), 1);
               check("bp_hold", int'(neuron_out), v.exp_out);
               check("bp_busy", int'(busy), 1);
               check("bp_no_load", int'(rst_mac), 0);
            end
            start = 1'b0;
            out_ready = 1'b1;
         end
         @(negedge clk);
         check("idle_after_hs", int'(busy), 0);
         check("valid_after_hs", int'(out_valid), 0);
      end
      $display("job len=%0d wb=%0d xb=%0d bias=%0d shift=%0d -> out=%0d lat=%0d reads=%0d",
               v.len, v.w_base, v.x_base, v.bias, v.shift, neuron_out, lat, rd_n);
   endtask

   vec_t vecs[6];
   vec_t post;
   int   t1, t2;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         w_mem[i] = 8'd0;
         x_mem[i] = 8'd0;
      end
      w_mem[0] = 8'd2; w_mem[1] = 8'd3; w_mem[2] = 8'd4;
      x_mem[100] = 8'd5; x_mem[101] = 8'd6; x_mem[102] = 8'd7;
      w_mem[10] = 8'd255; w_mem[11] = 8'd255;
      x_mem[110] = 8'd255; x_mem[111] = 8'd255;
      w_mem[1022] = 8'd1; w_mem[1023] = 8'd1;
      for (int i = 200; i < 204; i++) x_mem[i] = 8'd1;

      //            len  wb    xb   bias shift exp
      vecs[0] = '{  0,   0,    0,   37,  0,    37 };   // bias only
      vecs[1] = '{  3,   0,    100, 1,   0,    57 };   // 1+10+18+28
      vecs[2] = '{  2,   10,   110, 0,   4,    255};   // 64514>>4=4032, saturates
      vecs[3] = '{  2,   10,   110, 0,   8,    252};   // 64514>>8
      vecs[4] = '{  4,   1022, 200, 0,   0,    7  };   // address wrap: 1+1+2+3
      vecs[5] = '{  1,   0,    100, 200, 1,    105};   // (200+10)>>1

      rstn = 1'b0; start = 1'b0; out_ready = 1'b1;
      len = '0; w_base = '0; x_base = '0; bias = '0; shift = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_mem_rd", int'(mem_rd), 0);
      check("rst_rst_mac", int'(rst_mac), 0);
      check("rst_en_mac", int'(en_mac), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_w_addr", int'(w_addr), 0);
      check("rst_x_addr", int'(x_addr), 0);
      check("rst_neuron", int'(neuron_out), 0);
      check("rst_bias_out", int'(bias_out), 0);
      rstn = 1'b1;

      for (int i = 0; i < 6; i++) run_job(vecs[i], 1'b0);

      // Backpressure with an ignored START during the stall
      run_job(vecs[1], 1'b1);

      // Back-to-back: START held high, OUT_READY high, LEN=0 -> 4 cycles per job
      @(negedge clk);
      len = '0; bias = 8'd9; shift = '0; start = 1'b1; out_ready = 1'b1;
      t1 = -1; t2 = -1;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (out_valid && t1 < 0) t1 = c;
         else if (out_valid && t2 < 0) begin
            t2 = c;
            start = 1'b0;
            break;
         end
      end
      check("b2b_first_valid", t1, 3);
      check("b2b_period", t2 - t1, 4);
      check("b2b_out", int'(neuron_out), 9);
      $display("back-to-back valid at cycles %0d and %0d", t1, t2);
      repeat (3) @(negedge clk);

      // Reset mid-stream of a long job
      @(negedge clk);
      len = ADDR_W'(784); w_base = '0; x_base = ADDR_W'(100); bias = 8'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      check("long_in_stream", int'(en_mac), 1);
      rstn = 1'b0;
      @(negedge clk);
      check("mid_busy", int'(busy), 0);
      check("mid_mem_rd", int'(mem_rd), 0);
      check("mid_en_mac", int'(en_mac), 0);
      check("mid_rst_mac", int'(rst_mac), 0);
      check("mid_valid", int'(out_valid), 0);
      check("mid_w_addr", int'(w_addr), 0);
      check("mid_x_addr", int'(x_addr), 0);
      check("mid_neuron", int'(neuron_out), 0);
      check("mid_bias_out", int'(bias_out), 0);
      rstn = 1'b1;
      t1 = 0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         if (out_valid || busy) t1++;
      end
      check("no_valid_after_abort", t1, 0);
      $display("reset mid-stream: aborted job produced %0d active cycles", t1);

      post = '{1, 1, 101, 5, 0, 23};   // 5 + 3*6
      run_job(post, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
